// File: rtl/lcd_adc_pkg.sv
// Shared state encoding, LCD constants and digit helpers for the ADC-to-LCD display sequencer.
package lcd_adc_pkg;

   typedef enum logic [2:0] {IDLE, LATCH, CONV, CMD, D3, D2, D1, D0} state_e;

   localparam logic [7:0] LCD_LINE1   = 8'h80;
   localparam logic [7:0] LCD_LINE2   = 8'hC0;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic       RS_CMD      = 1'b0;
   localparam logic       RS_DATA     = 1'b1;
   localparam int         ADC_W       = 12;

   function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

   function automatic logic [8:0] char_word(input logic [3:0] digit, input logic blank);
      logic [8:0] res;
      if (blank) begin
         res = {RS_DATA, ASCII_SPACE};
      end else begin
         res = {RS_DATA, ASCII_ZERO + {4'h0, digit}};
      end
      return res;
   endfunction

endpackage

// File: rtl/lcd_adc_scheduler_bcd_iter.sv
// adc_bcd_iter: 12-cycle shift-add-3 binary to BCD converter; the caller pulses start and
// watches done, which flags the final iteration (bcd is complete from the following cycle).
module adc_bcd_iter
   import lcd_adc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ADC_W-1:0] bin,
   output logic             done,
   output logic [15:0]      bcd
);

   localparam logic [3:0] ITER_END  = 4'(ADC_W);
   localparam logic [3:0] ITER_LAST = 4'(ADC_W - 1);

   logic [ADC_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [15:0]      adj_s;

   // Next-state for the shift register: load on start, then one adjust+shift per cycle.
   always_comb begin
      adj_s = {bcd_adjust(bcd_q[15:12]), bcd_adjust(bcd_q[11:8]),
               bcd_adjust(bcd_q[7:4]),   bcd_adjust(bcd_q[3:0])};
      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      if (start) begin
         bin_d = bin;
         bcd_d = 16'h0000;
         cnt_d = 4'd0;
      end else if (cnt_q < ITER_END) begin
         bcd_d = {adj_s[14:0], bin_q[ADC_W-1]};
         bin_d = {bin_q[ADC_W-2:0], 1'b0};
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Converter registers; the counter parks at ITER_END when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= {ADC_W{1'b0}};
         bcd_q <= 16'h0000;
         cnt_q <= ITER_END;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == ITER_LAST);
   assign bcd  = bcd_q;

endmodule

// File: rtl/lcd_adc_scheduler.sv
// lcd_adc_scheduler: round-robin ADC channel readout to LCD words over valid/ready.
// Optional build macro LCD_LEADING_ZERO_BLANK_EN replaces leading zeros (D3..D1) with spaces.
module lcd_adc_scheduler
   import lcd_adc_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int REFRESH_CYC = 2_500_000
)(
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic [NUM_CH*ADC_W-1:0] adc_data,
   output logic [8:0]              lcd_word,
   output logic                    lcd_valid,
   input  logic                    lcd_ready,
   output logic                    busy,
   output logic [2:0]              ch_idx
);

   localparam int               CNT_W    = $clog2(REFRESH_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYC - 1);
   localparam logic [2:0]       CH_LAST  = 3'(NUM_CH - 1);

   state_e           state_q, state_d;
   logic [2:0]       ch_q, ch_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] refresh_q, refresh_d;
   logic [8:0]       word_q, word_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic             tick_s, xfer_s, start_s, conv_done_s;
   logic [ADC_W-1:0] sample_s;
   logic [15:0]      bcd_s;
   logic [7:0]       cmd_addr_s;
   logic             blank3_s, blank2_s, blank1_s;

   assign tick_s   = (refresh_q == CNT_LAST);
   assign xfer_s   = valid_q && lcd_ready;
   assign start_s  = (state_q == LATCH);
   assign sample_s = adc_data[int'(ch_q)*ADC_W +: ADC_W];

   adc_bcd_iter u_bcd (
      .clk   (clk_50),
      .rst_n (rst_n),
      .start (start_s),
      .bin   (sample_s),
      .done  (conv_done_s),
      .bcd   (bcd_s)
   );

`ifdef LCD_LEADING_ZERO_BLANK_EN
   assign blank3_s = (bcd_s[15:12] == 4'd0);
   assign blank2_s = blank3_s && (bcd_s[11:8] == 4'd0);
   assign blank1_s = blank2_s && (bcd_s[7:4] == 4'd0);
`else
   assign blank3_s = 1'b0;
   assign blank2_s = 1'b0;
   assign blank1_s = 1'b0;
`endif

   assign cmd_addr_s = ((ch_d < 3'd4) ? LCD_LINE1 : LCD_LINE2) | {3'b000, ch_d[1:0], 2'b00};

   // Sequencer next state, refresh counter and one-deep pending frame request.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      refresh_d = tick_s ? {CNT_W{1'b0}} : refresh_q + CNT_W'(1);
      if (tick_s && (state_q != IDLE)) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
      case (state_q)
         IDLE: begin
            if (tick_s || pending_q) begin
               state_d   = LATCH;
               ch_d      = 3'd0;
               pending_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         LATCH:   state_d = CONV;
         CONV:    state_d = conv_done_s ? CMD : CONV;
         CMD:     state_d = xfer_s ? D3 : CMD;
         D3:      state_d = xfer_s ? D2 : D3;
         D2:      state_d = xfer_s ? D1 : D2;
         D1:      state_d = xfer_s ? D0 : D1;
         D0: begin
            if (!xfer_s) begin
               state_d = D0;
            end else if (ch_q != CH_LAST) begin
               state_d = LATCH;
               ch_d    = ch_q + 3'd1;
            end else begin
               // A request seen during the frame (or on its last cycle) restarts without idling.
               ch_d      = 3'd0;
               state_d   = (pending_q || tick_s) ? LATCH : IDLE;
               pending_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered output words: a new word is loaded only on entry to an output state.
   always_comb begin
      valid_d = (state_d inside {CMD, D3, D2, D1, D0});
      busy_d  = (state_d != IDLE);
      word_d  = word_q;
      if (state_d != state_q) begin
         case (state_d)
            CMD:     word_d = {RS_CMD, cmd_addr_s};
            D3:      word_d = char_word(bcd_s[15:12], blank3_s);
            D2:      word_d = char_word(bcd_s[11:8], blank2_s);
            D1:      word_d = char_word(bcd_s[7:4], blank1_s);
            D0:      word_d = char_word(bcd_s[3:0], 1'b0);
            default: word_d = word_q;
         endcase
      end else begin
         word_d = word_q;
      end
   end

   // Sequencer and output registers.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ch_q      <= 3'd0;
         pending_q <= 1'b0;
         refresh_q <= {CNT_W{1'b0}};
         word_q    <= 9'h000;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         pending_q <= pending_d;
         refresh_q <= refresh_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign lcd_word  = word_q;
   assign lcd_valid = valid_q;
   assign busy      = busy_q;
   assign ch_idx    = ch_q;

endmodule

// File: tb/tb_lcd_adc_scheduler.sv
// Self-checking bench for lcd_adc_scheduler: frame-level scoreboard plus stall, overlap and reset sequences.
module tb_lcd_adc_scheduler;

   localparam int NUM_CH      = 8;
   localparam int REFRESH_CYC = 160;
   localparam int WPF         = NUM_CH * 5;

   logic                   clk_50    = 1'b0;
   logic                   rst_n     = 1'b0;
   logic [NUM_CH*12-1:0]   adc_data  = '0;
   logic                   lcd_ready = 1'b1;
   logic [8:0]             lcd_word;
   logic                   lcd_valid;
   logic                   busy;
   logic [2:0]             ch_idx;

   always #10 clk_50 = ~clk_50;

   lcd_adc_scheduler #(.NUM_CH(NUM_CH), .REFRESH_CYC(REFRESH_CYC)) dut (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .adc_data  (adc_data),
      .lcd_word  (lcd_word),
      .lcd_valid (lcd_valid),
      .lcd_ready (lcd_ready),
      .busy      (busy),
      .ch_idx    (ch_idx)
   );

   typedef struct {
      int         ch;
      int         sample;
      logic [8:0] cmd;
      logic [8:0] d3;
      logic [8:0] d2;
      logic [8:0] d1;
      logic [8:0] d0;
   } vec_t;

   vec_t       tbl [8];
   logic [8:0] exp_frame [WPF];
   logic [8:0] sb_q [$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   bit         bbusy = 1'b0;
   bit         pend = 1'b0;
   int         frame_left = 0;
   int         frame_start = 0;
   int         last_len = 0;
   int         first_xfer = -1;
   logic [8:0] first_word = 9'h000;
   int         busy_chk = 2;
   bit         prev_stall = 1'b0;
   logic [8:0] prev_word = 9'h000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [8:0] dig(input int v);
      return {1'b1, 8'h30 + 8'(v)};
   endfunction

   function automatic void put(input int ch, input logic [8:0] c, input logic [8:0] d3,
                               input logic [8:0] d2, input logic [8:0] d1, input logic [8:0] d0);
      logic [8:0] w [4];
      bit lead;
      w = '{d3, d2, d1, d0};
      lead = 1'b1;
`ifdef LCD_LEADING_ZERO_BLANK_EN
      for (int i = 0; i < 3; i++) begin
         if (lead && w[i] == 9'h130) w[i] = 9'h120;
         else lead = 1'b0;
      end
`endif
      exp_frame[ch*5] = c;
      for (int j = 0; j < 4; j++) exp_frame[ch*5 + 1 + j] = w[j];
   endfunction

   function automatic void set_ch(input int ch, input int val);
      logic [7:0] base;
      base = (ch < 4) ? 8'h80 : 8'hC0;
      adc_data[ch*12 +: 12] = 12'(val);
      put(ch, {1'b0, base | 8'(4 * (ch % 4))}, dig(val / 1000), dig((val / 100) % 10),
          dig((val / 10) % 10), dig(val % 10));
   endfunction

   function automatic void start_frame();
      for (int i = 0; i < WPF; i++) sb_q.push_back(exp_frame[i]);
      frame_left  = WPF;
      frame_start = cyc;
      bbusy       = 1'b1;
   endfunction

   always @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Scoreboard: predicts frame starts from the refresh period and compares every transfer.
   always @(negedge clk_50) begin
      bit tick;
      int pos;
      if (!rst_n) begin
         sb_q.delete();
         bbusy      = 1'b0;
         pend       = 1'b0;
         frame_left = 0;
         first_xfer = -1;
         prev_stall = 1'b0;
         busy_chk   = 2;
      end else begin
         tick = ((cyc % REFRESH_CYC) == REFRESH_CYC - 1);
         if (busy_chk != 2) begin
            check("busy_after_frame_end", {31'd0, busy}, busy_chk);
            if (busy_chk == 0) check("ch_idx_idle", {29'd0, ch_idx}, 32'd0);
            busy_chk = 2;
         end
         if (prev_stall) begin
            check("stall_valid_held", {31'd0, lcd_valid}, 32'd1);
            check("stall_word_held", {23'd0, lcd_word}, {23'd0, prev_word});
         end
         if (lcd_valid && lcd_ready) begin
            pos = WPF - frame_left;
            if (first_xfer < 0) begin
               first_xfer = cyc;
               first_word = lcd_word;
            end
            if (frame_left == 0 || sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_word: got %0h, expected no transfer (cycle %0d)", lcd_word, cyc);
            end else begin
               check("lcd_word", {23'd0, lcd_word}, {23'd0, sb_q.pop_front()});
               if (pos % 5 == 0) check("ch_idx_at_cmd", {29'd0, ch_idx}, 32'(pos / 5));
               frame_left--;
               if (frame_left == 0) begin
                  last_len = cyc - frame_start;
                  if (pend || tick) begin
                     pend = 1'b0;
                     tick = 1'b0;
                     start_frame();
                     busy_chk = 1;
                  end else begin
                     bbusy    = 1'b0;
                     busy_chk = 0;
                  end
               end
            end
         end
         if (tick) begin
            if (bbusy) pend = 1'b1;
            else       start_frame();
         end
         prev_stall = lcd_valid && !lcd_ready;
         prev_word  = lcd_word;
      end
   end

   task automatic wait_frame(input string name, input int bound);
      int n = 0;
      while (!bbusy && n < bound) begin @(posedge clk_50); #2; n++; end
      while ((bbusy || sb_q.size() != 0) && n < bound) begin @(posedge clk_50); #2; n++; end
      if (n >= bound) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: timeout after %0d cycles, expected frame completion", name, n);
      end
   endtask

   task automatic wait_pos(input string name, input int p, input int bound);
      int n = 0;
      do begin
         @(posedge clk_50);
         #1;
         n++;
      end while (!(bbusy && (WPF - frame_left) == p && lcd_valid) && n < bound);
      if (n >= bound) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: timeout after %0d cycles, expected word %0d of a frame", name, n, p);
      end
   endtask

   initial begin
      #(20 * 6000);
      $display("FAIL watchdog: simulation exceeded 6000 cycles, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0, 4095, 9'h080, 9'h134, 9'h130, 9'h139, 9'h135};
      tbl[1] = '{1,    0, 9'h084, 9'h130, 9'h130, 9'h130, 9'h130};
      tbl[2] = '{2,    7, 9'h088, 9'h130, 9'h130, 9'h130, 9'h137};
      tbl[3] = '{3,  999, 9'h08C, 9'h130, 9'h139, 9'h139, 9'h139};
      tbl[4] = '{4, 1000, 9'h0C0, 9'h131, 9'h130, 9'h130, 9'h130};
      tbl[5] = '{5, 1234, 9'h0C4, 9'h131, 9'h132, 9'h133, 9'h134};
      tbl[6] = '{6, 4000, 9'h0C8, 9'h134, 9'h130, 9'h130, 9'h130};
      tbl[7] = '{7,   59, 9'h0CC, 9'h130, 9'h130, 9'h135, 9'h139};

      // Reset state.
      repeat (3) @(negedge clk_50);
      check("reset_lcd_word", {23'd0, lcd_word}, 32'h000);
      check("reset_lcd_valid", {31'd0, lcd_valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_ch_idx", {29'd0, ch_idx}, 32'd0);

      // ch0 = 4095, all others 0; first CMD at tick + 14.
      for (int c = 0; c < NUM_CH; c++) set_ch(c, (c == 0) ? 4095 : 0);
      @(posedge clk_50);
      #5 rst_n = 1'b1;
      wait_frame("frame_a", 400);
      check("first_cmd_cycle", 32'(first_xfer), 32'd173);
      check("frame_len_nominal", 32'(last_len), 32'd144);

      // Table-driven frame: every channel gets a distinct sample.
      for (int i = 0; i < 8; i++) begin
         adc_data[tbl[i].ch*12 +: 12] = 12'(tbl[i].sample);
         put(tbl[i].ch, tbl[i].cmd, tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0);
      end
      wait_frame("frame_table", 400);
      check("frame_len_table", 32'(last_len), 32'd144);

      // Five-cycle stall on D2 of ch2.
      wait_pos("stall_d2", 12, 400);
      lcd_ready = 1'b0;
      repeat (5) @(posedge clk_50);
      #1 lcd_ready = 1'b1;
      wait_frame("frame_stall", 400);
      check("frame_len_stalled", 32'(last_len), 32'd149);

      // Long stall so a frame spans two refresh ticks.
      wait_pos("long_stall", 0, 400);
      lcd_ready = 1'b0;
      repeat (200) @(posedge clk_50);
      #1 lcd_ready = 1'b1;
      wait_frame("frame_overlap", 1000);

      // Reset during D1 of ch3.
      wait_pos("reset_d1", 18, 400);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_valid", {31'd0, lcd_valid}, 32'd0);
      check("async_reset_busy", {31'd0, busy}, 32'd0);
      check("async_reset_ch_idx", {29'd0, ch_idx}, 32'd0);
      check("async_reset_word", {23'd0, lcd_word}, 32'h000);
      repeat (2) @(posedge clk_50);
      #5 rst_n = 1'b1;
      wait_frame("frame_after_reset", 400);
      check("post_reset_first_cycle", 32'(first_xfer), 32'd173);
      check("post_reset_first_word", {23'd0, first_word}, 32'h080);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
